// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Shares the single write port of the 32x32 CPU register file between N_REQ
// writeback sources. Sources are granted round-robin through valid/ready
// handshakes. The accepted write is registered onto wen/waddr/wdata, so a
// handshake in cycle t appears on the write port in cycle t+1.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   flush      kills the current arbitration and the write that would appear
//              next cycle; the pointer returns to requester 0
//   req_valid  per-requester write pending
//   req_ready  per-requester grant (combinational, at most one bit set)
//   req_addr   5-bit destination register per requester, packed [5i+4:5i]
//   req_data   32-bit write data per requester, packed [32i+31:32i]
//   wen        register-file write enable (registered)
//   waddr      register-file write address (registered)
//   wdata      register-file write data (registered)
//   wb_busy    one-hot mask of the register currently being written
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [5*N_REQ-1:0]    req_addr,
  input  logic [32*N_REQ-1:0]   req_data,
  output logic                  wen,
  output logic [4:0]            waddr,
  output logic [31:0]           wdata,
  output logic [31:0]           wb_busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             wen_q, wen_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;

  logic             grant_vld;
  logic [PTR_W-1:0] grant_idx;
  int               scan_idx;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration: scan from rr_ptr upward, wrapping modulo N_REQ.
  // The wrap is a compare-and-subtract so non-power-of-2 N_REQ works.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written in this block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= N_REQ) scan_idx = scan_idx - N_REQ;
      if (!grant_vld && req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = PTR_W'(scan_idx);
      end
    end
    // Reset and flush suppress the grant entirely, so no handshake occurs.
    if (rst || flush) grant_vld = 1'b0;
    if (grant_vld) req_ready[grant_idx] = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Next-state: pointer advance and output-stage load.
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (grant_vld) begin
      rr_ptr_d = (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + PTR_W'(1);
      waddr_d  = req_addr[5*int'(grant_idx) +: 5];
      wdata_d  = req_data[32*int'(grant_idx) +: 32];
      // A write to r0 consumes the grant but never reaches the register file.
      wen_d    = (req_addr[5*int'(grant_idx) +: 5] != 5'd0);
    end
    if (flush) rr_ptr_d = '0;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    if (rst) begin
      rr_ptr_q <= '0;
      wen_q    <= 1'b0;
      waddr_q  <= 5'd0;
      wdata_q  <= 32'd0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign wen     = wen_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;
  // wen is never set for r0, so bit 0 of the mask stays clear.
  assign wb_busy = wen_q ? (32'd1 << waddr_q) : 32'd0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
//
// Directed testbench for regfile_wb_arbiter with N_REQ = 3. Inputs change
// 1 ns after the rising edge. req_ready is sampled 1 ns later, and the
// registered outputs are sampled 1 ns after the following edge.
// -----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [5*N-1:0]  req_addr;
  logic [32*N-1:0] req_data;
  logic            wen;
  logic [4:0]      waddr;
  logic [31:0]     wdata;
  logic [31:0]     wb_busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf_model [32];

  regfile_wb_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wen       (wen),
    .waddr     (waddr),
    .wdata     (wdata),
    .wb_busy   (wb_busy)
  );

  always #5 clk = ~clk;

  // Register-file model that commits whatever appears on the write port.
  always @(posedge clk) if (wen) rf_model[waddr] <= wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[5*i +: 5]  = a;
    req_data[32*i +: 32] = d;
  endtask

  // Return the round-robin pointer to 0 with a one-cycle flush.
  task automatic clear_ptr();
    req_valid = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic chk_ready(input string name, input logic [N-1:0] exp);
    // Inline comparison kept per call site through this thin wrapper name.
    checks++;
    if (req_ready !== exp) begin
      errors++;
      $display("FAIL %s: req_ready=%b expected %b", name, req_ready, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush = 1'b0;
    req_valid = '1;
    set_req(0, 5'd0, 32'h0);
    set_req(1, 5'd0, 32'h0);
    set_req(2, 5'd0, 32'h0);
    tick();
    tick();
    checks++;
    if (req_ready !== 3'b000) begin
      errors++; $display("FAIL reset_ready: got %b expected 000", req_ready);
    end
    checks++;
    if (wen !== 1'b0 || wb_busy !== 32'd0) begin
      errors++; $display("FAIL reset_wen_busy: wen=%b busy=%h expected 0/0", wen, wb_busy);
    end
    checks++;
    if (waddr !== 5'd0 || wdata !== 32'd0) begin
      errors++; $display("FAIL reset_addr_data: waddr=%0d wdata=%h expected 0/0", waddr, wdata);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL reset_release_grant: got %b expected 001", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
  endtask

  task automatic test_single_write();
    clear_ptr();
    req_valid = 3'b010;
    set_req(1, 5'd5, 32'hDEADBEEF);
    #1;
    checks++;
    if (req_ready !== 3'b010) begin
      errors++; $display("FAIL single_ready: got %b expected 010", req_ready);
    end
    tick();
    checks++;
    if (wen !== 1'b1 || waddr !== 5'd5 || wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL single_out: wen=%b waddr=%0d wdata=%h expected 1/5/deadbeef", wen, waddr, wdata);
    end
    checks++;
    if (wb_busy !== 32'h0000_0020) begin
      errors++; $display("FAIL single_busy: got %h expected 00000020", wb_busy);
    end
    // Pointer is now 2: with everyone valid, requester 2 wins.
    req_valid = 3'b111;
    #1;
    checks++;
    if (req_ready !== 3'b100) begin
      errors++; $display("FAIL single_ptr: got %b expected 100", req_ready);
    end
    req_valid = '0;
    tick();
    checks++;
    if (wen !== 1'b0) begin
      errors++; $display("FAIL single_idle_wen: got %b expected 0", wen);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_ready;
    clear_ptr();
    set_req(0, 5'd1, 32'h1111_0001);
    set_req(1, 5'd2, 32'h2222_0002);
    set_req(2, 5'd3, 32'h3333_0003);
    req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_ready = '0;
      exp_ready[c % 3] = 1'b1;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", c, req_ready, exp_ready);
      end
      tick();
      checks++;
      if (wen !== 1'b1 || waddr !== 5'((c % 3) + 1)) begin
        errors++;
        $display("FAIL rr_waddr[%0d]: wen=%b waddr=%0d expected 1/%0d", c, wen, waddr, (c % 3) + 1);
      end
    end
    checks++;
    if (wdata !== 32'h3333_0003 || wb_busy !== 32'h0000_0008) begin
      errors++; $display("FAIL rr_last: wdata=%h busy=%h expected 33330003/00000008", wdata, wb_busy);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_write_r0();
    clear_ptr();
    req_valid = 3'b100;
    set_req(2, 5'd0, 32'h1234_5678);
    #1;
    checks++;
    if (req_ready !== 3'b100) begin
      errors++; $display("FAIL r0_ready: got %b expected 100", req_ready);
    end
    tick();
    req_valid = '0;
    checks++;
    if (wen !== 1'b0 || wb_busy !== 32'd0) begin
      errors++; $display("FAIL r0_nowrite: wen=%b busy=%h expected 0/0", wen, wb_busy);
    end
    checks++;
    if (wdata !== 32'h1234_5678 || waddr !== 5'd0) begin
      errors++; $display("FAIL r0_regs: waddr=%0d wdata=%h expected 0/12345678", waddr, wdata);
    end
    req_valid = 3'b111;
    #1;
    checks++;
    if (req_ready !== 3'b001) begin
      errors++; $display("FAIL r0_wrap: got %b expected 001", req_ready);
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_flush();
    clear_ptr();
    req_valid = 3'b001;
    set_req(0, 5'd7, 32'h7777_7777);
    #1;
    chk_ready("flush_hs_ready", 3'b001);
    tick();
    flush = 1'b1;
    req_valid = 3'b111;
    #1;
    chk_ready("flush_kill_ready", 3'b000);
    checks++;
    if (wen !== 1'b1 || waddr !== 5'd7) begin
      errors++; $display("FAIL flush_inflight: wen=%b waddr=%0d expected 1/7", wen, waddr);
    end
    tick();
    flush = 1'b0;
    req_valid = '0;
    checks++;
    if (wen !== 1'b0) begin
      errors++; $display("FAIL flush_dropped: wen=%b expected 0", wen);
    end
    // Without the flush the pointer would be 1; it must be back at 0.
    req_valid = 3'b111;
    #1;
    chk_ready("flush_ptr", 3'b001);
    // Flush together with a valid request: no grant, no write next cycle.
    flush = 1'b1;
    req_valid = 3'b010;
    set_req(1, 5'd11, 32'hBBBB_0011);
    #1;
    chk_ready("flush_same_cycle", 3'b000);
    tick();
    flush = 1'b0;
    req_valid = '0;
    checks++;
    if (wen !== 1'b0) begin
      errors++; $display("FAIL flush_same_cycle_wen: wen=%b expected 0", wen);
    end
    tick();
  endtask

  task automatic test_contention();
    clear_ptr();
    // Burn requester 0's turn with an r0 write so the pointer sits at 1.
    req_valid = 3'b001;
    set_req(0, 5'd0, 32'h0);
    tick();
    req_valid = 3'b011;
    set_req(0, 5'd9, 32'h0000_000A);
    set_req(1, 5'd9, 32'h0000_000B);
    #1;
    chk_ready("cont_first", 3'b010);
    tick();
    checks++;
    if (wen !== 1'b1 || waddr !== 5'd9 || wdata !== 32'h0000_000B) begin
      errors++; $display("FAIL cont_t1: wen=%b waddr=%0d wdata=%h expected 1/9/0000000b", wen, waddr, wdata);
    end
    req_valid = 3'b001;
    #1;
    chk_ready("cont_second", 3'b001);
    tick();
    req_valid = '0;
    checks++;
    if (wen !== 1'b1 || waddr !== 5'd9 || wdata !== 32'h0000_000A) begin
      errors++; $display("FAIL cont_t2: wen=%b waddr=%0d wdata=%h expected 1/9/0000000a", wen, waddr, wdata);
    end
    tick();
    checks++;
    if (rf_model[9] !== 32'h0000_000A) begin
      errors++; $display("FAIL cont_r9: got %h expected 0000000a", rf_model[9]);
    end
  endtask

  task automatic test_rst_midstream();
    clear_ptr();
    req_valid = 3'b001;
    set_req(0, 5'd4, 32'h4444_4444);
    tick();
    rst = 1'b1;
    req_valid = 3'b111;
    #1;
    chk_ready("rstmid_ready", 3'b000);
    checks++;
    if (wen !== 1'b1 || waddr !== 5'd4 || wb_busy !== 32'h0000_0010) begin
      errors++; $display("FAIL rstmid_t1: wen=%b waddr=%0d busy=%h expected 1/4/00000010", wen, waddr, wb_busy);
    end
    tick();
    rst = 1'b0;
    req_valid = '0;
    checks++;
    if (wen !== 1'b0 || waddr !== 5'd0 || wb_busy !== 32'd0) begin
      errors++; $display("FAIL rstmid_t2: wen=%b waddr=%0d busy=%h expected 0/0/0", wen, waddr, wb_busy);
    end
    req_valid = 3'b111;
    #1;
    chk_ready("rstmid_ptr", 3'b001);
    req_valid = '0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    for (int r = 0; r < 32; r++) rf_model[r] = 32'd0;
    test_reset();
    test_single_write();
    test_round_robin();
    test_write_r0();
    test_flush();
    test_contention();
    test_rst_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback-port arbiter for the 32x32 CPU register file. Shares the file's single write port between N_REQ writeback sources (ALU, load unit, multiply/divide unit) using round-robin arbitration, valid/ready handshakes and a registered output stage. Sits between the pipeline's writeback sources and the register file's `wen`/`waddr`/`wdata` inputs. Also exports a one-hot busy mask so hazard logic can see the write in flight.

## Interface

- `N_REQ`, default 3: number of writeback requesters, from 2 to 8.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `flush`, in, 1: synchronous kill of the in-flight write and of the current arbitration.
- `req_valid`, in, N_REQ: requester i has a write pending.
- `req_ready`, out, N_REQ: requester i is granted this cycle. Combinational.
- `req_addr`, in, 5*N_REQ: destination register of requester i, at bits [5i+4:5i].
- `req_data`, in, 32*N_REQ: write data of requester i, at bits [32i+31:32i].
- `wen`, out, 1: register-file write enable. Registered.
- `waddr`, out, 5: register-file write address. Registered.
- `wdata`, out, 32: register-file write data. Registered.
- `wb_busy`, out, 32: bit k is set while a write to register k is on the output stage.

## Operation

**State**
- Round-robin pointer `rr_ptr`, width clog2(N_REQ).
- Output-stage registers `wen`, `waddr`, `wdata`.

**Arbitration (combinational, each cycle)**
- Scan requesters starting at `rr_ptr`, wrapping modulo N_REQ.
- The first requester with `req_valid` set gets its `req_ready` bit set.
- At most one `req_ready` bit is set.
- `req_ready` is 0 for every requester whose `req_valid` is 0.
- If `flush` or `rst` is set, `req_ready` is all zeros.

**Acceptance**
- A handshake is `req_valid[i] && req_ready[i]`.
- A requester holds its `req_addr` and `req_data` stable until accepted. The arbiter does not check this.

**Pointer update**
- On a handshake with requester i, `rr_ptr` becomes `(i+1) mod N_REQ`. Wrap-around from N_REQ-1 goes to 0.
- With no handshake, `rr_ptr` is unchanged.
- `flush` and `rst` force `rr_ptr` to 0.

**Output stage**
- On a handshake with i: next `waddr` = `req_addr[i]`, next `wdata` = `req_data[i]`.
- Next `wen` = 1 only when `req_addr[i]` != 0. A write to r0 is accepted and consumes the grant, but no write is issued.
- With no handshake: next `wen` = 0, and `waddr`/`wdata` hold their previous values.
- `flush` forces next `wen` = 0. This drops any write that would have appeared in the following cycle. A write already visible on `wen` this cycle still completes in the register file.

**Busy mask**
- `wb_busy` = `(wen ? 1 << waddr : 0)`.
- Bit 0 is always 0.

**Width rules**
- Index arithmetic is modulo N_REQ, including non-power-of-2 values.
- No truncation of address or data.

## Timing

**Reset values**
- `wen` = 0, `waddr` = 0, `wdata` = 0.
- `rr_ptr` = 0.
- `req_ready` = 0 while `rst` is asserted.
- `wb_busy` = 0.

**Latency and throughput**
- Handshake in cycle t gives `wen`/`waddr`/`wdata` in cycle t+1. The register file commits at the end of t+1, and its read bypass makes the data visible in t+1.
- Throughput is one write per cycle, with back-to-back grants allowed.

**Ready path**
- `req_ready` has a combinational path from `req_valid`, `flush` and `rst`.
- There is no path from `req_ready` to `req_valid`.

**Simultaneous same-address requests**
- Only the granted requester writes in t+1. The loser writes in a later cycle.
- Ordering between sources is the pipeline's responsibility.

**Boundary cases**
- `flush` and `req_valid` in the same cycle: no grant, no write in t+1.
- `rst` mid-stream, with a handshake in t and `rst` in t+1: `wen` is 1 in t+1 and 0 in t+2. The pending grant order is lost.
- All requesters valid: grants cycle in order `rr_ptr`, `rr_ptr`+1, and so on, wrapping. No requester waits more than N_REQ-1 cycles.

## Test plan

- **Reset:** assert `rst` 2 cycles with all `req_valid` set -> `req_ready` = 000, `wen` = 0, `wb_busy` = 0. In the first cycle after release, requester 0 is granted.
- **Single write:** N_REQ=3, only requester 1 valid, addr 5, data 0xDEADBEEF in cycle t -> `req_ready` = 010 in t. In t+1: `wen` = 1, `waddr` = 5, `wdata` = 0xDEADBEEF, `wb_busy` = 0x00000020. `rr_ptr` = 2.
- **Round-robin fairness:** all three valid continuously, addrs 1/2/3 -> grants 0, 1, 2, 0, 1, 2 in consecutive cycles. `waddr` sequence is 1, 2, 3, 1, 2, 3, lagging by one cycle, and `wen` stays 1 throughout.
- **Write to r0:** requester 2 valid, addr 0, data 0x12345678 -> `req_ready` = 100. Next cycle `wen` = 0 and `wb_busy` = 0. `rr_ptr` wraps to 0.
- **Flush:**
  - Handshake with requester 0 (addr 7) in t, `flush` in t+1 -> `wen` = 1 and `waddr` = 7 in t+1; `req_ready` = 000 in t+1; `wen` = 0 in t+2; `rr_ptr` = 0.
  - Second case: handshake in t with `flush` also asserted in t -> no grant, `wen` = 0 in t+1.
- **Same-address contention:** requesters 0 and 1 both target r9 with data 0xA and 0xB, `rr_ptr` = 1 -> r9 gets 0xB in t+1 and 0xA in t+2. Reading r9 after t+2 returns 0xA.
